// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between a hart (master) and a data memory (slave).
interface dmem_responder_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [1:0]      req_width;
  logic            req_signed;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_write, req_width, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_width, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder over a little-endian word RAM with fixed response latency.
// Optional macro DMEM_MISALIGN_ERR_EN turns misaligned halfword/word accesses into access faults.
module dmem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [XLEN-1:0]  ADDR_LIMIT = XLEN'(64'(DEPTH_WORDS) << 2);
  localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    WRITE_BYTE     = 2'd0,
    WRITE_HALFWORD = 2'd1,
    WRITE_WORD     = 2'd2,
    WRITE_RESERVED = 2'd3
  } write_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              ram_we;

  logic [31:0]       mem [DEPTH_WORDS];

  write_width_t      width;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [31:0]       word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              misalign;
  logic              req_err;
  logic [XLEN-1:0]   load_data;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lanes;

  // Request decode: address split, fault detection, load extraction and store lane steering.
  always_comb begin
    width       = write_width_t'(bus.req_width);
    idx         = bus.req_addr[IDX_W+1:2];
    lane        = bus.req_addr[1:0];
    word        = mem[idx];
    byte_sel    = word[8*lane +: 8];
    half_sel    = word[16*lane[1] +: 16];
    misalign    = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    misalign    = ((width == WRITE_HALFWORD) && lane[0]) ||
                  ((width == WRITE_WORD) && (lane != 2'd0));
`endif
    req_err     = (bus.req_addr >= ADDR_LIMIT) || (width == WRITE_RESERVED) || misalign;
    load_data   = '0;
    byte_en     = 4'b0000;
    wdata_lanes = bus.req_wdata[31:0];
    case (width)
      WRITE_BYTE: begin
        load_data   = {{(XLEN-8){bus.req_signed & byte_sel[7]}}, byte_sel};
        byte_en     = 4'b0001 << lane;
        wdata_lanes = {4{bus.req_wdata[7:0]}};
      end
      WRITE_HALFWORD: begin
        load_data   = {{(XLEN-16){bus.req_signed & half_sel[15]}}, half_sel};
        byte_en     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{bus.req_wdata[15:0]}};
      end
      WRITE_WORD: begin
        load_data   = XLEN'(word);
        byte_en     = 4'b1111;
      end
      default: begin
        load_data   = '0;
        byte_en     = 4'b0000;
      end
    endcase
  end

  // Next-state and response capture; the access itself happens on the accept edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          err_d   = req_err;
          rdata_d = (req_err || bus.req_write) ? '0 : load_data;
          ram_we  = bus.req_write && !req_err;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= (state_d == IDLE);
      resp_valid_q <= (state_d == RESP);
    end
  end

  // RAM is deliberately not reset; a reset edge also blocks a coincident store.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          mem[idx][8*k +: 8] <= wdata_lanes[8*k +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a byte-array reference memory.
module tb_dmem_responder;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] ref_mem [DEPTH*4];

  dmem_responder_if #(.XLEN(XLEN)) bus ();

  dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] w);
    bit e;
    e = (a >= LIMIT) || (w == 2'd3);
`ifdef DMEM_MISALIGN_ERR_EN
    if (w == 2'd1 && a[0]) e = 1'b1;
    if (w == 2'd2 && a[1:0] != 2'd0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w, input bit sg);
    int unsigned base;
    int unsigned v;
    if (model_err(a, w)) return 32'd0;
    case (w)
      2'd0: begin
        v = ref_mem[a];
        if (sg && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        base = a - (a % 2);
        v = ref_mem[base] + 256 * ref_mem[base+1];
        if (sg && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: begin
        base = a - (a % 4);
        v = ref_mem[base] + 256 * ref_mem[base+1] + 65536 * ref_mem[base+2]
            + 16777216 * ref_mem[base+3];
      end
    endcase
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] wd);
    int unsigned base;
    if (model_err(a, w)) return;
    case (w)
      2'd0: ref_mem[a] = wd[7:0];
      2'd1: begin
        base = a - (a % 2);
        ref_mem[base]   = wd[7:0];
        ref_mem[base+1] = wd[15:8];
      end
      default: begin
        base = a - (a % 4);
        for (int i = 0; i < 4; i++) ref_mem[base+i] = 8'((wd >> (8*i)) & 32'hFF);
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction; returns sampled in RESP. With retire set, steps into the following IDLE cycle.
  task automatic access(input string tag, input bit wr, input logic [1:0] w, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input bit retire,
                        output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] exp_rd;
    bit exp_er;
    exp_er = model_err(a, w);
    exp_rd = wr ? 32'd0 : model_load(a, w, sg);
    if (wr) model_store(a, w, wd);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_width  = w;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_width  = 2'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(LAT - 1));
    rd = bus.resp_rdata;
    er = bus.resp_err;
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, 32'(er), 32'(exp_er));
    if (retire) begin
      @(posedge clk); #1;
      check({tag, ".idle"}, {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);
    end
  endtask

  logic [31:0] rd, held;
  logic        er;

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_width  = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset.req_ready", 32'(bus.req_ready), 32'd1);
    check("reset.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset.rdata", bus.resp_rdata, 32'd0);
    check("reset.err", 32'(bus.resp_err), 32'd0);

    access("st_w4", 1'b1, 2'd2, 1'b0, 32'h4, 32'h8899_AABB, 1'b1, rd, er);
    access("ld_w4", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b1, rd, er);
    check("ld_w4.const", rd, 32'h8899_AABB);
    access("ld_b5s", 1'b0, 2'd0, 1'b1, 32'h5, 32'h0, 1'b1, rd, er);
    check("ld_b5s.const", rd, 32'hFFFF_FFAA);
    access("ld_b5u", 1'b0, 2'd0, 1'b0, 32'h5, 32'h0, 1'b1, rd, er);
    check("ld_b5u.const", rd, 32'h0000_00AA);
    access("ld_h6s", 1'b0, 2'd1, 1'b1, 32'h6, 32'h0, 1'b1, rd, er);
    check("ld_h6s.const", rd, 32'hFFFF_8899);

    access("st_b7", 1'b1, 2'd0, 1'b0, 32'h7, 32'h0000_0011, 1'b1, rd, er);
    access("ld_w4b", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b1, rd, er);
    check("ld_w4b.const", rd, 32'h1199_AABB);

    // Response back-pressure: everything must hold while resp_ready is low.
    bus.resp_ready = 1'b0;
    access("stall", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b0, rd, er);
    held = rd;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall.resp_valid", 32'(bus.resp_valid), 32'd1);
      check("stall.rdata", bus.resp_rdata, held);
      check("stall.req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall.release", {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);

    access("ld_oor", 1'b0, 2'd2, 1'b0, LIMIT, 32'h0, 1'b1, rd, er);
    check("ld_oor.err", 32'(er), 32'd1);
    access("st_rsvd", 1'b1, 2'd3, 1'b0, 32'h4, 32'hDEAD_BEEF, 1'b1, rd, er);
    check("st_rsvd.err", 32'(er), 32'd1);
    access("st_oor", 1'b1, 2'd2, 1'b0, LIMIT + 32'h4, 32'hCAFE_F00D, 1'b1, rd, er);
    access("ld_w4c", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b1, rd, er);
    check("ld_w4c.const", rd, 32'h1199_AABB);

    access("ld_w6", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b1, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
    check("ld_w6.const", rd, 32'h0);
    check("ld_w6.err_const", 32'(er), 32'd1);
`else
    check("ld_w6.const", rd, 32'h1199_AABB);
    check("ld_w6.err_const", 32'(er), 32'd0);
`endif

    // Reset while waiting: the transaction vanishes without a response.
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_width  = 2'd2;
    bus.req_addr   = 32'h4;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    check("rstwait.in_wait", {30'd0, bus.req_ready, bus.resp_valid}, 32'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwait.req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstwait.no_resp", 32'(bus.resp_valid), 32'd0);
    end
    access("post_rst", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 1'b1, rd, er);

    for (int i = 0; i < 64; i++) begin
      access("fill", 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b1, rd, er);
    end

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [1:0]  w;
      int          r;
      r = $urandom_range(0, 9);
      a = (r == 0) ? LIMIT + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      w = (r == 9) ? 2'd3 : 2'(r % 3);
      access("rand", 1'($urandom), w, 1'($urandom), a, $urandom, 1'b1, rd, er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
